// File: rtl/snake_step_ctrl.sv
// Game sequencer for the snake Core: game FSM, speed-scaled step strobe,
// reversal-proof heading filter and a free-running LFSR for random_direction.
module snake_step_ctrl #(
  parameter int unsigned TICK_BASE = 50,
  parameter int unsigned TICK_DEC  = 4,
  parameter int unsigned TICK_MIN  = 10,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic [2:0] user_direction,
  input  logic [3:0] size,
  input  logic       done,
  output logic       o_core_rst,
  output logic       o_step,
  output logic [1:0] o_direction,
  output logic [1:0] random_direction,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [15:0] BASE16 = 16'(TICK_BASE);
  localparam logic [15:0] DEC16  = 16'(TICK_DEC);
  localparam logic [15:0] MIN16  = 16'(TICK_MIN);
  localparam logic [1:0]  DIR_RIGHT = 2'b01;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [1:0]  dir_q;
  logic [1:0]  pend_q;
  logic [7:0]  lfsr_q;

  logic [15:0] prod_d;
  logic [15:0] period_d;
  logic [1:0]  ref_d;
  logic        accept_d;
  logic        fb_d;

  // Period = max(TICK_MIN, TICK_BASE - TICK_DEC*size), saturating at the floor.
  always_comb begin
    prod_d = DEC16 * {12'd0, size};
    if (prod_d >= BASE16) begin
      period_d = MIN16;
    end else if ((BASE16 - prod_d) < MIN16) begin
      period_d = MIN16;
    end else begin
      period_d = BASE16 - prod_d;
    end
  end

  // Strobes are combinational so they can be suppressed in the done/reset cycle.
  assign o_step     = (state_q == ST_RUN) && (cnt_q == 16'd0) && !done && !i_rst;
  assign o_core_rst = (state_q == ST_INIT) && !i_rst;

  // In a step cycle the reference is the heading about to be committed.
  always_comb begin
    ref_d    = o_step ? pend_q : dir_q;
    accept_d = !user_direction[2] && (user_direction[1:0] != (ref_d ^ 2'b10));
    fb_d     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      dir_q   <= DIR_RIGHT;
      pend_q  <= DIR_RIGHT;
      lfsr_q  <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], fb_d};
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          state_q <= ST_RUN;
          dir_q   <= DIR_RIGHT;
          pend_q  <= DIR_RIGHT;
          cnt_q   <= BASE16 - 16'd1;
        end
        ST_RUN: begin
          if (done) begin
            state_q <= ST_OVER;
          end else begin
            if (i_pause) begin
              state_q <= ST_PAUSE;
            end
            // The pause cycle itself still counts and may still step.
            if (o_step) begin
              cnt_q <= period_d - 16'd1;
              dir_q <= pend_q;
            end else if (cnt_q != 16'd0) begin
              cnt_q <= cnt_q - 16'd1;
            end
            if (accept_d) begin
              pend_q <= user_direction[1:0];
            end
          end
        end
        ST_PAUSE: begin
          if (i_pause) begin
            state_q <= ST_RUN;
          end
        end
        ST_OVER: begin
          if (i_start) begin
            state_q <= ST_INIT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_direction      = dir_q;
  assign random_direction = lfsr_q[1:0];
  assign o_state          = state_q;

endmodule

// File: doc/snake_step_ctrl.md
# snake_step_ctrl

Game sequencer in front of the snake `Core`. It owns the game state machine (idle / init / run / pause / over) and pulses `Core`'s reset at game start. It paces `Core` with a step strobe whose period shrinks as the snake grows, and filters user direction presses into a committed heading that cannot reverse. It also supplies `Core`'s `random_direction` input from a free-running LFSR.

## Interface
- `TICK_BASE`, 50: step period in cycles at size 0.
- `TICK_DEC`, 4: cycles removed from the period per unit of `size`.
- `TICK_MIN`, 10: floor on the step period; requires `TICK_MIN` >= 2 and `TICK_BASE` >= `TICK_MIN`.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `i_clk`  in  1  single clock; all state changes on its rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  start pulse; single cycle.
- `i_pause`  in  1  pause-toggle pulse; single cycle.
- `user_direction`  in  3  button input.
  - `3'b1xx` = no press.
  - `3'b0dd` = press of direction `dd`: 00 up, 01 right, 10 down, 11 left.
- `size`  in  4  snake length from `Core`.
- `done`  in  1  game-over flag from `Core`.
- `o_core_rst`  out  1  one-cycle reset pulse to `Core`.
- `o_step`  out  1  one-cycle step strobe to `Core`.
- `o_direction`  out  2  committed heading.
- `random_direction`  out  2  equals `lfsr[1:0]`.
- `o_state`  out  3  current state: IDLE=0, INIT=1, RUN=2, PAUSE=3, OVER=4.

## Operation
- Reset values of outputs and internal registers:
  - state = IDLE; `o_core_rst` = 0; `o_step` = 0.
  - `o_direction` = 01; `pending` = 01; cnt = 0.
  - lfsr = `LFSR_SEED`, so `random_direction` = 01.
- State transitions:
  - IDLE: `i_start` -> INIT. `i_start` has priority over `i_pause` when both arrive in the same cycle.
  - INIT (exactly one cycle): `o_core_rst` = 1; `o_direction` and `pending` <= 01; cnt <= `TICK_BASE`-1. Always proceeds to RUN.
  - RUN:
    - `done` = 1 -> OVER. This has priority over everything else, and `o_step` is suppressed in that cycle.
    - Otherwise `i_pause` -> PAUSE.
    - `i_start` is ignored.
  - PAUSE: `i_pause` -> RUN. cnt, `pending` and `o_direction` are frozen; presses are ignored.
  - OVER: `i_start` -> INIT. All other inputs are ignored; `o_step` = 0.
- Step counter (RUN only, combinational strobe):
  - `o_step` = (state==RUN) & (cnt==0) & ~`done`.
  - When cnt != 0: cnt decrements by 1 each cycle.
  - When `o_step` fires: cnt <= period-1.
- Period rule:
  - period = max(`TICK_MIN`, `TICK_BASE` − `TICK_DEC`·`size`), using `size` sampled in the step cycle.
  - Compute in 16-bit unsigned with saturating subtraction: if the product is ≥ `TICK_BASE`, the result is `TICK_MIN`.
- Direction filter (RUN only):
  - Reference direction ref = `o_step` ? `pending` : `o_direction`.
  - A press `dd` is accepted into `pending` iff `dd` != (ref ^ 2'b10), i.e. it is not the reverse of ref.
  - With several accepted presses between steps, the last one wins.
  - On `o_step`, `o_direction` <= `pending` as it held at the start of that cycle. A press accepted in the step cycle takes effect at the following step.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts every cycle in all states, including reset-exit; it stops only while `i_rst` is high.
  - The lock-up state 0 cannot be reached from a nonzero seed.
- Reset mid-game: `i_rst` in any state returns everything to the reset values on the next edge. No `o_step` or `o_core_rst` is issued in that cycle.

## Timing
- `i_start` sampled at edge N:
  - INIT during cycle N+1 (`o_core_rst` high).
  - RUN from cycle N+2.
  - First `o_step` in cycle N+1+`TICK_BASE`.
- Between consecutive steps: exactly period cycles, rising edge to rising edge. `o_step` is high for exactly one cycle.
- `done` asserted in cycle M while in RUN: `o_state` = 4 from cycle M+1; no `o_step` at or after M.
- `i_pause` at cycle P with cnt = k:
  - PAUSE covers cycles P+1 .. Q, where Q is the cycle of the second `i_pause`.
  - The next step comes k cycles after entering RUN at Q+1, i.e. the pause adds exactly (Q−P) cycles.
- Direction latency: a press accepted in cycle t reaches `o_direction` at the edge ending the first step cycle strictly after t.

## Test plan
- Start and pacing:
  - Stimulus: reset, then `i_start` at cycle 3, `size` = 0.
  - Required: `o_core_rst` high at cycle 4 only; `o_step` at cycles 54, 104, 154.
  - Required: `o_direction` = 01 throughout.
- Speed-up and floor:
  - Stimulus: hold `size` = 5 from before the first step; then change to 15.
  - Required: steps 30 cycles apart at `size` = 5.
  - Required: after the step at which 15 is sampled, steps are 10 cycles apart (saturation; no wrap to large values).
- Reversal filter:
  - Heading right: press left (3'b011) -> rejected; `o_direction` stays 01 after the next step.
  - Then press up (3'b000) then down (3'b010) before one step -> `o_direction` = 10 after that step.
  - Press right in the step cycle where `pending` = up -> accepted; up commits at this step, right commits at the next.
- Pause and resume:
  - Stimulus: `i_pause` at cnt = 20 in RUN; hold 37 cycles; `i_pause` again.
  - Required: `o_state` = 3 during the hold; next step exactly 20 cycles after resume.
  - Required: presses during the pause have no effect.
- Game over and restart:
  - Stimulus: `done` = 1 in the same cycle cnt = 0.
  - Required: no `o_step`; `o_state` = 4 next cycle.
  - Stimulus: `i_start` while in OVER -> required: INIT pulse, `o_direction` = 01, normal first-step timing.
- Mid-game reset and LFSR:
  - Stimulus: `i_rst` during RUN -> required: `o_state` = 0, `o_direction` = 01, lfsr = A5 next cycle.
  - Required: `random_direction` sequence after reset matches the reference LFSR model for 300 cycles; the LFSR has period 255.
